// File: rtl/inst_loader_if.sv
// Fetch-stage and instruction-bus signal bundle for inst_loader.
// The loader takes the master modport. The fetch stage and the bus take the slave modport.
interface inst_loader_if;
  logic        INST_RDEN;
  logic [31:0] INST_RIADDR;
  logic        INST_RVALID;
  logic [31:0] INST_ROADDR;
  logic [31:0] INST_RDATA;
  logic        INST_RERR;
  logic        MEM_WAIT;
  logic        BUS_RD_REQ;
  logic [31:0] BUS_RD_ADDR;
  logic        BUS_RD_ACK;
  logic        BUS_RD_RVALID;
  logic [31:0] BUS_RD_DATA;
  logic        BUS_RD_ERR;

  modport master (
    input  INST_RDEN, INST_RIADDR,
    output INST_RVALID, INST_ROADDR, INST_RDATA, INST_RERR, MEM_WAIT,
    output BUS_RD_REQ, BUS_RD_ADDR,
    input  BUS_RD_ACK, BUS_RD_RVALID, BUS_RD_DATA, BUS_RD_ERR
  );

  modport slave (
    output INST_RDEN, INST_RIADDR,
    input  INST_RVALID, INST_ROADDR, INST_RDATA, INST_RERR, MEM_WAIT,
    input  BUS_RD_REQ, BUS_RD_ADDR,
    output BUS_RD_ACK, BUS_RD_RVALID, BUS_RD_DATA, BUS_RD_ERR
  );
endinterface

// File: rtl/inst_loader.sv
// Instruction fetch loader: turns fetch-stage requests into single outstanding bus reads,
// with flush discard, misaligned/bus-error NOP substitution and a one-cycle response pulse.
module inst_loader #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FLUSH,
  inst_loader_if.master     ifc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  state_t      state_r;
  logic        discard_r;
  logic        bus_req_r;
  logic [31:0] addr_r;
  logic        inst_rvalid_r;
  logic [31:0] inst_roaddr_r;
  logic [31:0] inst_rdata_r;
  logic        inst_rerr_r;
  logic        mem_wait_s;

  // Fetch FSM with registered bus request and fetch response
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r       <= ST_IDLE;
      discard_r     <= 1'b0;
      bus_req_r     <= 1'b0;
      addr_r        <= 32'h0000_0000;
      inst_rvalid_r <= 1'b0;
      inst_roaddr_r <= 32'h0000_0000;
      inst_rdata_r  <= NOP_INST;
      inst_rerr_r   <= 1'b0;
    end else begin
      inst_rvalid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // No launch while a response is visible so the PC can advance first
          if (ifc.INST_RDEN && !FLUSH && !inst_rvalid_r) begin
            if (ifc.INST_RIADDR[1:0] != 2'b00) begin
              inst_rvalid_r <= 1'b1;
              inst_rerr_r   <= 1'b1;
              inst_rdata_r  <= NOP_INST;
              inst_roaddr_r <= ifc.INST_RIADDR;
            end else begin
              addr_r    <= ifc.INST_RIADDR;
              bus_req_r <= 1'b1;
              state_r   <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          // The request is never retracted; a flush only marks the beat for discard
          if (ifc.BUS_RD_ACK) begin
            bus_req_r <= 1'b0;
            if (discard_r || FLUSH) begin
              state_r <= ST_DROP;
            end else begin
              state_r <= ST_WAIT;
            end
          end else if (FLUSH) begin
            discard_r <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (ifc.BUS_RD_RVALID) begin
            state_r <= ST_IDLE;
            if (!FLUSH && !discard_r) begin
              inst_rvalid_r <= 1'b1;
              inst_roaddr_r <= addr_r;
              inst_rerr_r   <= ifc.BUS_RD_ERR;
              inst_rdata_r  <= ifc.BUS_RD_ERR ? NOP_INST : ifc.BUS_RD_DATA;
            end
          end else if (FLUSH) begin
            state_r <= ST_DROP;
          end
        end
        ST_DROP: begin
          if (ifc.BUS_RD_RVALID) begin
            state_r   <= ST_IDLE;
            discard_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          discard_r <= 1'b0;
          bus_req_r <= 1'b0;
        end
      endcase
    end
  end

  // Hold the fetch stage while a fetch is pending or about to launch
  always_comb begin
    mem_wait_s = 1'b0;
    if (state_r != ST_IDLE) begin
      mem_wait_s = 1'b1;
    end else if (ifc.INST_RDEN && !inst_rvalid_r) begin
      mem_wait_s = 1'b1;
    end else begin
      mem_wait_s = 1'b0;
    end
  end

  assign ifc.BUS_RD_REQ  = bus_req_r;
  assign ifc.BUS_RD_ADDR = addr_r;
  assign ifc.INST_RVALID = inst_rvalid_r;
  assign ifc.INST_ROADDR = inst_roaddr_r;
  assign ifc.INST_RDATA  = inst_rdata_r;
  assign ifc.INST_RERR   = inst_rerr_r;
  assign ifc.MEM_WAIT    = mem_wait_s;

endmodule

// File: tb/tb_inst_loader.sv
// Directed-vector bench for inst_loader; expected values are hand-derived constants.
module tb_inst_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic CLK;
  logic RST;
  logic FLUSH;
  int   n_vec;
  int   n_err;

  inst_loader_if ifc ();

  inst_loader #(.NOP_INST(NOP)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .FLUSH (FLUSH),
    .ifc   (ifc.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Normal aligned fetch: ACK at launch+1, RVALID at launch+2, response at launch+3
  task automatic fetch_ok(input logic [31:0] addr, input logic [31:0] data, input logic berr,
                          input logic [31:0] exp_data, input logic exp_err);
    ifc.INST_RDEN   = 1'b1;
    ifc.INST_RIADDR = addr;
    tick();
    chk("fo_req", {31'd0, ifc.BUS_RD_REQ}, 32'd1);
    chk("fo_addr", ifc.BUS_RD_ADDR, addr);
    ifc.BUS_RD_ACK = 1'b1;
    tick();
    ifc.BUS_RD_ACK    = 1'b0;
    ifc.BUS_RD_RVALID = 1'b1;
    ifc.BUS_RD_DATA   = data;
    ifc.BUS_RD_ERR    = berr;
    tick();
    ifc.BUS_RD_RVALID = 1'b0;
    ifc.BUS_RD_ERR    = 1'b0;
    #1;
    chk("fo_rvalid", {31'd0, ifc.INST_RVALID}, 32'd1);
    chk("fo_roaddr", ifc.INST_ROADDR, addr);
    chk("fo_rdata", ifc.INST_RDATA, exp_data);
    chk("fo_rerr", {31'd0, ifc.INST_RERR}, {31'd0, exp_err});
    chk("fo_memwait", {31'd0, ifc.MEM_WAIT}, 32'd0);
    tick();
    ifc.INST_RDEN = 1'b0;
    chk("fo_nolaunch", {31'd0, ifc.BUS_RD_REQ}, 32'd0);
    chk("fo_pulse", {31'd0, ifc.INST_RVALID}, 32'd0);
    chk("fo_hold", ifc.INST_RDATA, exp_data);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    RST = 1'b0;
    FLUSH = 1'b0;
    ifc.INST_RDEN = 1'b0;
    ifc.INST_RIADDR = 32'h0000_0000;
    ifc.BUS_RD_ACK = 1'b0;
    ifc.BUS_RD_RVALID = 1'b0;
    ifc.BUS_RD_DATA = 32'h0000_0000;
    ifc.BUS_RD_ERR = 1'b0;

    // Reset values
    #12;
    chk("rst_rvalid", {31'd0, ifc.INST_RVALID}, 32'd0);
    chk("rst_rdata", ifc.INST_RDATA, NOP);
    chk("rst_roaddr", ifc.INST_ROADDR, 32'h0000_0000);
    chk("rst_rerr", {31'd0, ifc.INST_RERR}, 32'd0);
    chk("rst_busreq", {31'd0, ifc.BUS_RD_REQ}, 32'd0);
    chk("rst_busaddr", ifc.BUS_RD_ADDR, 32'h0000_0000);
    chk("rst_memwait0", {31'd0, ifc.MEM_WAIT}, 32'd0);
    ifc.INST_RDEN = 1'b1;
    #1;
    chk("rst_memwait1", {31'd0, ifc.MEM_WAIT}, 32'd1);
    ifc.INST_RDEN = 1'b0;
    #2;
    RST = 1'b1;
    tick();

    // Basic fetch
    ifc.INST_RDEN = 1'b1;
    ifc.INST_RIADDR = 32'h2000_0000;
    #1;
    chk("idle_memwait", {31'd0, ifc.MEM_WAIT}, 32'd1);
    fetch_ok(32'h2000_0000, 32'h0050_0093, 1'b0, 32'h0050_0093, 1'b0);

    // Bus stall: ACK delayed 5 cycles, stray RVALID during REQ ignored
    ifc.INST_RDEN = 1'b1;
    ifc.INST_RIADDR = 32'h2000_0040;
    tick();
    for (int i = 0; i < 6; i++) begin
      ifc.BUS_RD_RVALID = (i == 2);
      ifc.BUS_RD_ACK = (i == 5);
      #1;
      chk("stall_req", {31'd0, ifc.BUS_RD_REQ}, 32'd1);
      chk("stall_addr", ifc.BUS_RD_ADDR, 32'h2000_0040);
      chk("stall_wait", {31'd0, ifc.MEM_WAIT}, 32'd1);
      chk("stall_noresp", {31'd0, ifc.INST_RVALID}, 32'd0);
      tick();
    end
    ifc.BUS_RD_ACK = 1'b0;
    ifc.BUS_RD_RVALID = 1'b1;
    ifc.BUS_RD_DATA = 32'h1111_2222;
    chk("stall_waitst", {31'd0, ifc.MEM_WAIT}, 32'd1);
    tick();
    ifc.BUS_RD_RVALID = 1'b0;
    ifc.INST_RDEN = 1'b0;
    chk("stall_rvalid", {31'd0, ifc.INST_RVALID}, 32'd1);
    chk("stall_rdata", ifc.INST_RDATA, 32'h1111_2222);
    chk("stall_roaddr", ifc.INST_ROADDR, 32'h2000_0040);
    tick();

    // Flush in WAIT together with RVALID
    ifc.INST_RDEN = 1'b1;
    ifc.INST_RIADDR = 32'h2000_0080;
    tick();
    ifc.BUS_RD_ACK = 1'b1;
    tick();
    ifc.BUS_RD_ACK = 1'b0;
    ifc.INST_RDEN = 1'b0;
    FLUSH = 1'b1;
    ifc.BUS_RD_RVALID = 1'b1;
    ifc.BUS_RD_DATA = 32'hBAD0_0001;
    tick();
    FLUSH = 1'b0;
    ifc.BUS_RD_RVALID = 1'b0;
    chk("fw_norvalid", {31'd0, ifc.INST_RVALID}, 32'd0);
    chk("fw_idle", {31'd0, ifc.MEM_WAIT}, 32'd0);
    fetch_ok(32'h2000_0100, 32'h00A0_0113, 1'b0, 32'h00A0_0113, 1'b0);

    // Flush in REQ before ACK
    ifc.INST_RDEN = 1'b1;
    ifc.INST_RIADDR = 32'h2000_0200;
    tick();
    FLUSH = 1'b1;
    ifc.INST_RDEN = 1'b0;
    tick();
    FLUSH = 1'b0;
    chk("fr_keepreq", {31'd0, ifc.BUS_RD_REQ}, 32'd1);
    chk("fr_keepaddr", ifc.BUS_RD_ADDR, 32'h2000_0200);
    ifc.BUS_RD_ACK = 1'b1;
    tick();
    ifc.BUS_RD_ACK = 1'b0;
    chk("fr_reqdone", {31'd0, ifc.BUS_RD_REQ}, 32'd0);
    chk("fr_dropwait", {31'd0, ifc.MEM_WAIT}, 32'd1);
    ifc.BUS_RD_RVALID = 1'b1;
    ifc.BUS_RD_DATA = 32'hDEAD_BEEF;
    tick();
    ifc.BUS_RD_RVALID = 1'b0;
    chk("fr_norvalid", {31'd0, ifc.INST_RVALID}, 32'd0);
    chk("fr_idle", {31'd0, ifc.MEM_WAIT}, 32'd0);
    tick();
    chk("fr_norvalid2", {31'd0, ifc.INST_RVALID}, 32'd0);
    fetch_ok(32'h2000_0300, 32'h0031_0193, 1'b0, 32'h0031_0193, 1'b0);

    // Flush in WAIT without RVALID goes through DROP
    ifc.INST_RDEN = 1'b1;
    ifc.INST_RIADDR = 32'h2000_0600;
    tick();
    ifc.BUS_RD_ACK = 1'b1;
    tick();
    ifc.BUS_RD_ACK = 1'b0;
    ifc.INST_RDEN = 1'b0;
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    chk("fd_dropwait", {31'd0, ifc.MEM_WAIT}, 32'd1);
    ifc.BUS_RD_RVALID = 1'b1;
    ifc.BUS_RD_DATA = 32'hCAFE_0001;
    tick();
    ifc.BUS_RD_RVALID = 1'b0;
    chk("fd_norvalid", {31'd0, ifc.INST_RVALID}, 32'd0);
    chk("fd_idle", {31'd0, ifc.MEM_WAIT}, 32'd0);

    // Misaligned fetch: no bus request, error response next cycle
    ifc.INST_RDEN = 1'b1;
    ifc.INST_RIADDR = 32'h2000_0002;
    tick();
    ifc.INST_RDEN = 1'b0;
    chk("mis_nobus", {31'd0, ifc.BUS_RD_REQ}, 32'd0);
    chk("mis_rvalid", {31'd0, ifc.INST_RVALID}, 32'd1);
    chk("mis_rerr", {31'd0, ifc.INST_RERR}, 32'd1);
    chk("mis_rdata", ifc.INST_RDATA, 32'h0000_0013);
    chk("mis_roaddr", ifc.INST_ROADDR, 32'h2000_0002);
    tick();
    chk("mis_pulse", {31'd0, ifc.INST_RVALID}, 32'd0);

    // Bus error on a normal fetch
    fetch_ok(32'h2000_0400, 32'h1234_5678, 1'b1, 32'h0000_0013, 1'b1);

    // Asynchronous reset while in WAIT
    ifc.INST_RDEN = 1'b1;
    ifc.INST_RIADDR = 32'h2000_0500;
    tick();
    ifc.BUS_RD_ACK = 1'b1;
    tick();
    ifc.BUS_RD_ACK = 1'b0;
    ifc.INST_RDEN = 1'b0;
    #1;
    chk("rw_inwait", {31'd0, ifc.MEM_WAIT}, 32'd1);
    RST = 1'b0;
    #1;
    chk("rw_memwait", {31'd0, ifc.MEM_WAIT}, 32'd0);
    chk("rw_busaddr", ifc.BUS_RD_ADDR, 32'h0000_0000);
    chk("rw_rdata", ifc.INST_RDATA, NOP);
    chk("rw_rerr", {31'd0, ifc.INST_RERR}, 32'd0);
    chk("rw_roaddr", ifc.INST_ROADDR, 32'h0000_0000);
    tick();
    RST = 1'b1;
    ifc.BUS_RD_RVALID = 1'b1;
    ifc.BUS_RD_DATA = 32'h5555_AAAA;
    tick();
    ifc.BUS_RD_RVALID = 1'b0;
    chk("rw_stray", {31'd0, ifc.INST_RVALID}, 32'd0);
    chk("rw_idle", {31'd0, ifc.MEM_WAIT}, 32'd0);
    tick();
    chk("rw_stray2", {31'd0, ifc.INST_RVALID}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
